// File: rtl/line_window_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_window_if : pixel stream in / ROWS x COLS window out bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface line_window_if #(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 78,
  parameter int ROWS       = 3,
  parameter int COLS       = 2
);
  localparam int COL_W = $clog2(LINE_WORDS);

  logic                          in_valid;
  logic                          sof;
  logic [WORD_W-1:0]             data_in;
  logic                          win_valid;
  logic [ROWS*COLS*WORD_W-1:0]   win_data;
  logic [COL_W-1:0]              win_col;

  modport master (
    output in_valid, sof, data_in,
    input  win_valid, win_data, win_col
  );

  modport slave (
    input  in_valid, sof, data_in,
    output win_valid, win_data, win_col
  );
endinterface
`default_nettype wire

// File: rtl/line_window_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_window_buffer : sliding ROWS x COLS word window over a raster stream
// Rev 1.0
// ---------------------------------------------------------------------------
module line_window_buffer #(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 78,
  parameter int ROWS       = 3,
  parameter int COLS       = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  line_window_if.slave      bus
);
  localparam int c_depth = LINE_WORDS - COLS;
  localparam int c_col_w = $clog2(LINE_WORDS);
  localparam int c_row_w = $clog2(ROWS);
  localparam int c_ptr_w = (c_depth > 1) ? $clog2(c_depth) : 1;

  localparam logic [c_col_w-1:0] c_col_last  = c_col_w'(LINE_WORDS - 1);
  localparam logic [c_col_w-1:0] c_col_first = c_col_w'(COLS - 1);
  localparam logic [c_row_w-1:0] c_row_last  = c_row_w'(ROWS - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_last  = c_ptr_w'(c_depth - 1);

  logic [WORD_W-1:0]  r_shift [ROWS][COLS];
  logic [WORD_W-1:0]  w_delay_out [ROWS-1];
  logic [c_col_w-1:0] r_col;
  logic [c_row_w-1:0] r_row;
  logic [c_ptr_w-1:0] r_ptr;
  logic               r_started;
  logic               r_win_valid;

  logic               w_restart;
  logic [c_col_w-1:0] w_col_next;
  logic [c_row_w-1:0] w_row_next;
  logic [c_ptr_w-1:0] w_ptr_use;
  logic [c_ptr_w-1:0] w_ptr_next;
  logic [ROWS*COLS*WORD_W-1:0] w_win;

  // First word after reset, or any sof word, starts a fresh frame at line 0 / column 0.
  always_comb begin
    w_restart  = !r_started || bus.sof;
    w_col_next = '0;
    w_row_next = '0;
    w_ptr_use  = '0;
    if (!w_restart) begin
      w_col_next = (r_col == c_col_last) ? '0 : r_col + 1'b1;
      w_row_next = (r_col == c_col_last && r_row != c_row_last) ? r_row + 1'b1 : r_row;
      w_ptr_use  = r_ptr;
    end
    w_ptr_next = (w_ptr_use == c_ptr_last) ? '0 : w_ptr_use + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_shift[r][c] <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_ptr       <= '0;
      r_started   <= 1'b0;
      r_win_valid <= 1'b0;
    end else begin
      r_win_valid <= bus.in_valid && (w_row_next == c_row_last) && (w_col_next >= c_col_first);
      if (bus.in_valid) begin
        r_shift[0][0] <= bus.data_in;
        for (int r = 1; r < ROWS; r++)
          r_shift[r][0] <= w_delay_out[r-1];
        for (int r = 0; r < ROWS; r++)
          for (int c = 1; c < COLS; c++)
            r_shift[r][c] <= r_shift[r][c-1];
        r_col     <= w_col_next;
        r_row     <= w_row_next;
        r_ptr     <= w_ptr_next;
        r_started <= 1'b1;
      end
    end
  end

  // The oldest word of each row re-emerges LINE_WORDS-COLS acceptances later as the next row's newest.
  for (genvar r = 0; r < ROWS - 1; r++) begin : g_delay
    logic [WORD_W-1:0] mem [c_depth];

    always_ff @(posedge clk) begin
      if (bus.in_valid)
        mem[w_ptr_use] <= r_shift[r][COLS-1];
    end

    assign w_delay_out[r] = mem[w_ptr_use];
  end

  always_comb begin
    w_win = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        w_win[(r*COLS+c)*WORD_W +: WORD_W] = r_shift[r][c];
  end

  assign bus.win_data  = w_win;
  assign bus.win_col   = r_col;
  assign bus.win_valid = r_win_valid;
endmodule
`default_nettype wire

// File: tb/tb_line_window_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_line_window_buffer : randomized scoreboard bench for line_window_buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_line_window_buffer;
  localparam int WW  = 32;
  localparam int L   = 8;
  localparam int R   = 3;
  localparam int C   = 2;
  localparam int CW  = $clog2(L);
  localparam int DW  = R*C*WW;

  typedef struct {
    bit             valid;
    int             col;
    logic [DW-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  line_window_if #(.WORD_W(WW), .LINE_WORDS(L), .ROWS(R), .COLS(C)) bus ();

  line_window_buffer #(.WORD_W(WW), .LINE_WORDS(L), .ROWS(R), .COLS(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t          sb[$];
  logic [WW-1:0] hist[$];
  int            n = 0;
  int            checks = 0;
  int            failures = 0;
  logic [WW-1:0] val = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: window word (r,c) is frame acceptance n-(r*L+c); valid once R-1 lines and C-1 words are in.
  task automatic drive(input logic v, input logic s, input logic [WW-1:0] d);
    exp_t e;
    @(negedge clk);
    bus.in_valid = v;
    bus.sof      = s;
    bus.data_in  = d;
    if (v) begin
      if (s) begin
        n = 0;
        hist.delete();
      end
      hist.push_back(d);
      e.col   = n % L;
      e.valid = ((n / L) >= (R - 1)) && ((n % L) >= (C - 1));
      e.data  = '0;
      if (e.valid)
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++)
            e.data[(r*C+c)*WW +: WW] = hist[n - (r*L + c)];
      sb.push_back(e);
      n++;
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, DW'(bus.win_valid), '0);
    chk({tag, "_data"},  bus.win_data,       '0);
    chk({tag, "_col"},   DW'(bus.win_col),   '0);
  endtask

  // Monitor: pops one expectation per accepted word, otherwise checks that outputs hold.
  logic          m_acc;
  logic          m_rst;
  logic [DW-1:0] prev_data = '0;
  logic [CW-1:0] prev_col = '0;
  exp_t          m_e;

  always @(posedge clk) begin
    m_acc = bus.in_valid;
    m_rst = reset;
    #1;
    if (!m_rst) begin
      if (m_acc) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=output expected=none at %0t", $time);
        end else begin
          m_e = sb.pop_front();
          chk("win_valid", DW'(bus.win_valid), DW'(m_e.valid));
          chk("win_col",   DW'(bus.win_col),   DW'(m_e.col));
          if (m_e.valid)
            chk("win_data", bus.win_data, m_e.data);
        end
      end else begin
        chk("gap_valid", DW'(bus.win_valid), '0);
        chk("gap_data",  bus.win_data,       prev_data);
        chk("gap_col",   DW'(bus.win_col),   DW'(prev_col));
      end
    end
    prev_data = bus.win_data;
    prev_col  = bus.win_col;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic v;
    logic s;
    bus.in_valid = 1'b0;
    bus.sof      = 1'b0;
    bus.data_in  = '0;

    repeat (3) @(negedge clk);
    #1 check_cleared("rst");
    @(negedge clk);
    reset = 1'b0;

    // Continuous stream, data = acceptance index, sof at 0
    for (int i = 0; i <= 40; i++) begin
      drive(1'b1, i == 0, val);
      val++;
    end

    // 50% in_valid gaps with counting data
    for (int k = 0; k < 160; k++) begin
      v = 1'($urandom_range(1));
      drive(v, 1'b0, val);
      if (v) val++;
    end

    // sof mid-stream, values keep counting
    drive(1'b1, 1'b1, val);
    val++;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 1'b0, val);
      val++;
    end

    // Random data, random gaps, occasional sof (sof alone is ignored)
    for (int k = 0; k < 200; k++) begin
      v = 1'($urandom_range(1));
      s = ($urandom_range(15) == 0);
      drive(v, s, $urandom);
    end

    // Reset pulse mid-frame, then stream without sof
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, $urandom);
    drive(1'b0, 1'b0, '0);
    #2 reset = 1'b1;
    #1 check_cleared("async_rst");
    n = 0;
    hist.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, i);

    drive(1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    chk("sb_drain", DW'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
